cache_flush_walker: RTL and testbench
=====================================

Name: cache_flush_walker

Overview:
- Sequencer that walks every (set, way) of a cache during a flush.
- Supplies FlushAdr and FlushWay to the cache address mux and tag/dirty arrays. These are the same set-index lines the replacement block sees as CacheSetData/CacheSetTag.
- Requests a writeback for each valid+dirty line, then clears its dirty bit.
- Sits beside the replacement and victim logic, upstream of the array address select. Signals completion to the cache FSM.

Parameters:
- NUMWAYS, 4, ways per set (power of 2, ≥2)
- NUMLINES, 128, sets (power of 2, ≥2)
- SETLEN, 7, set-index width (≥ $clog2(NUMLINES))

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- FlushCache  in  1  start request; level, sampled in IDLE only
- FlushStage  in  1  abort flush (pipeline flush)
- ValidWay  in  NUMWAYS  valid bits of set at FlushAdr, one cycle after FlushAdr presented
- DirtyWay  in  NUMWAYS  dirty bits, same timing as ValidWay
- BusAck  in  1  writeback transfer complete
- FlushAdr  out  SETLEN  set index being walked
- FlushWay  out  NUMWAYS  one-hot way being walked
- WriteBackReq  out  1  write back line (FlushAdr, FlushWay)
- ClearDirty  out  1  clear dirty bit at (FlushAdr, FlushWay); one-cycle pulse
- FlushBusy  out  1  walker active (stall cache FSM)
- FlushDone  out  1  one-cycle completion pulse

Behaviour:
- Reset values:
  - State IDLE.
  - FlushAdr=0, FlushWay=1 (way 0).
  - All 1-bit outputs 0.
  - Reset mid-walk returns to IDLE the next edge, with no pulse outputs.
- States and transitions:
  - IDLE: if FlushCache=1 → READ; counters hold 0.
  - READ: FlushAdr/FlushWay drive the arrays → CHECK (fixed 1-cycle array latency).
  - CHECK: hit = |(ValidWay & DirtyWay & FlushWay).
    - hit → WRITEBACK.
    - else if Last → DONE.
    - else advance and → READ.
  - WRITEBACK: WriteBackReq=1 held, address and way stable. BusAck=1 → CLEAN. BusAck may arrive in the first WRITEBACK cycle or any later one.
  - CLEAN: ClearDirty=1 for exactly one cycle.
    - Last → DONE.
    - else advance and → READ.
  - DONE: FlushDone=1 → IDLE; counters reset to 0 on that edge.
- Outputs by state:
  - FlushBusy=1 in READ, CHECK, WRITEBACK, CLEAN, DONE.
  - FlushBusy=0 in IDLE.
- Walk order:
  - Way-major within a set: way 0..NUMWAYS-1, then the set increments.
  - Advance = FlushWay rotates left by 1. On wrap (FlushWay[NUMWAYS-1]=1), FlushWay→1 and FlushAdr+1.
  - Last = FlushAdr==NUMLINES-1 && FlushWay[NUMWAYS-1].
  - FlushAdr never exceeds NUMLINES-1; upper bits beyond $clog2(NUMLINES) are always 0.
- Abort:
  - FlushStage=1 in READ, CHECK, CLEAN or DONE → IDLE next edge, counters cleared.
  - In these states it overrides all other transitions. In CLEAN, ClearDirty still pulses that cycle.
  - In WRITEBACK, FlushStage is ignored; the walker waits for BusAck, then goes to IDLE (not CLEAN). The dirty bit is left set, which is harmless because the line data matches memory.
  - FlushDone never pulses on an abort.
- FlushCache held high after DONE starts a new walk from IDLE the following cycle (one IDLE cycle between walks).
- Clean-cache timing:
  - Each entry costs 2 cycles (READ, CHECK).
  - Each dirty entry adds 1 WRITEBACK cycle per cycle waited on BusAck, plus 1 CLEAN cycle.

Decomposition:
- Shared cache package holds:
  - flush state enum typedef {IDLE, READ, CHECK, WRITEBACK, CLEAN, DONE}, 3 bits.
  - localparam LOGNUMLINES.
- One sub-module: cache_flush_ctr.
  - Contents: set counter plus one-hot way rotator with sync clear, advance enable, and Last output.
  - Instantiated once; the FSM remains in cache_flush_walker.

Test Plan:
- NUMWAYS=4, NUMLINES=4, all clean; FlushCache high at edge 0 → entries visited (0,w0),(0,w1)…(3,w3); FlushDone high only in cycle 33; FlushBusy high cycles 1–33; WriteBackReq never asserted.
- Only set 2 way 1 valid+dirty, BusAck 3 cycles after WriteBackReq rises → WriteBackReq high 3 cycles at FlushAdr=2, FlushWay=4'b0010; ClearDirty pulse next cycle; FlushDone at cycle 37.
- Dirty but invalid line (Valid=0, Dirty=1) → no WriteBackReq; timing identical to the clean case.
- FlushStage asserted during CHECK of entry (1,w2) → IDLE next cycle; FlushAdr=0, FlushWay=4'b0001; no FlushDone; FlushBusy falls.
- FlushStage asserted during WRITEBACK with BusAck 2 cycles later → WriteBackReq held until BusAck; no ClearDirty; then IDLE.
- reset asserted mid-WRITEBACK → all outputs 0 and FlushWay=1 after the edge; BusAck arriving later is ignored.

Source files
------------

// File: rtl/cache_flush_walker_pkg.sv
// Shared definitions for the cache flush walker: FSM state encoding and
// default geometry used by the walker and its set/way counter.
package cache_flush_walker_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        CHECK     = 3'd2,
        WRITEBACK = 3'd3,
        CLEAN     = 3'd4,
        DONE      = 3'd5
    } flush_state_e;

    localparam int DEF_NUMWAYS  = 4;
    localparam int DEF_NUMLINES = 128;
    localparam int LOGNUMLINES  = $clog2(DEF_NUMLINES);

endpackage

// File: rtl/cache_flush_ctr.sv
// Set counter plus one-hot way rotator for the flush walk. Ways advance
// first; the set index increments when the way rotator wraps.
module cache_flush_ctr
    import cache_flush_walker_pkg::*;
#(
    parameter int NUMWAYS  = DEF_NUMWAYS,
    parameter int NUMLINES = DEF_NUMLINES,
    parameter int SETLEN   = LOGNUMLINES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               adv,
    output logic [SETLEN-1:0]  adr,
    output logic [NUMWAYS-1:0] way,
    output logic               last
);

    localparam logic [NUMWAYS-1:0] WAY0     = {{(NUMWAYS-1){1'b0}}, 1'b1};
    localparam logic [SETLEN-1:0]  ADR_LAST = SETLEN'(NUMLINES - 1);

    logic [SETLEN-1:0]  adr_q, adr_d;
    logic [NUMWAYS-1:0] way_q, way_d;
    logic               wrap;

    assign wrap = way_q[NUMWAYS-1];

    always_comb begin
        adr_d = adr_q;
        way_d = way_q;
        if (clr) begin
            adr_d = '0;
            way_d = WAY0;
        end else if (adv) begin
            way_d = {way_q[NUMWAYS-2:0], way_q[NUMWAYS-1]};
            // NUMLINES is a power of two, so ADR_LAST doubles as the index mask
            // that keeps bits above the real set index at zero.
            if (wrap) begin
                adr_d = (adr_q + 1'b1) & ADR_LAST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adr_q <= '0;
            way_q <= WAY0;
        end else begin
            adr_q <= adr_d;
            way_q <= way_d;
        end
    end

    assign adr  = adr_q;
    assign way  = way_q;
    assign last = (adr_q == ADR_LAST) && wrap;

endmodule

// File: rtl/cache_flush_walker.sv
// Flush sequencer: visits every (set, way), writes back valid+dirty lines,
// clears their dirty bits and pulses FlushDone when the whole cache is clean.
module cache_flush_walker
    import cache_flush_walker_pkg::*;
#(
    parameter int NUMWAYS  = DEF_NUMWAYS,
    parameter int NUMLINES = DEF_NUMLINES,
    parameter int SETLEN   = LOGNUMLINES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushCache,
    input  logic               FlushStage,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [NUMWAYS-1:0] DirtyWay,
    input  logic               BusAck,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               WriteBackReq,
    output logic               ClearDirty,
    output logic               FlushBusy,
    output logic               FlushDone
);

    flush_state_e state_q, state_d;
    logic         abort_q, abort_d;
    logic         ctr_clr, ctr_adv, last, hit;

    cache_flush_ctr #(
        .NUMWAYS  (NUMWAYS),
        .NUMLINES (NUMLINES),
        .SETLEN   (SETLEN)
    ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (ctr_clr),
        .adv   (ctr_adv),
        .adr   (FlushAdr),
        .way   (FlushWay),
        .last  (last)
    );

    assign hit = |(ValidWay & DirtyWay & FlushWay);

    always_comb begin
        state_d      = state_q;
        abort_d      = 1'b0;
        ctr_clr      = 1'b0;
        ctr_adv      = 1'b0;
        WriteBackReq = 1'b0;
        ClearDirty   = 1'b0;
        FlushDone    = 1'b0;
        FlushBusy    = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                ctr_clr = 1'b1;
                if (FlushCache) state_d = READ;
            end
            READ: begin
                if (FlushStage) begin
                    state_d = IDLE;
                    ctr_clr = 1'b1;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (FlushStage) begin
                    state_d = IDLE;
                    ctr_clr = 1'b1;
                end else if (hit) begin
                    state_d = WRITEBACK;
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                    ctr_adv = 1'b1;
                end
            end
            WRITEBACK: begin
                // A bus transfer cannot be cancelled; remember the abort and
                // honour it once the transfer completes.
                WriteBackReq = 1'b1;
                abort_d      = abort_q | FlushStage;
                if (BusAck) begin
                    abort_d = 1'b0;
                    if (abort_q | FlushStage) begin
                        state_d = IDLE;
                        ctr_clr = 1'b1;
                    end else begin
                        state_d = CLEAN;
                    end
                end
            end
            CLEAN: begin
                ClearDirty = 1'b1;
                if (FlushStage) begin
                    state_d = IDLE;
                    ctr_clr = 1'b1;
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                    ctr_adv = 1'b1;
                end
            end
            DONE: begin
                FlushDone = ~FlushStage;
                state_d   = IDLE;
                ctr_clr   = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ctr_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_cache_flush_walker.sv
// Directed bench for cache_flush_walker with a 4-way, 4-set geometry.
module tb_cache_flush_walker;

    logic       clk = 1'b0;
    logic       reset, FlushCache, FlushStage, BusAck;
    logic [3:0] ValidWay, DirtyWay;
    logic [2:0] FlushAdr;
    logic [3:0] FlushWay;
    logic       WriteBackReq, ClearDirty, FlushBusy, FlushDone;

    logic [3:0] valid_mem [4];
    logic [3:0] dirty_mem [4];

    int vectors     = 0;
    int miscompares = 0;

    int         done_cyc, done_cnt, busy_cnt, wb_cnt, clr_cnt, visits;
    logic       order_ok, finished;
    logic [2:0] wb_adr, clr_adr;
    logic [3:0] wb_way, clr_way;

    always #5 clk = ~clk;

    assign ValidWay = valid_mem[FlushAdr[1:0]];
    assign DirtyWay = dirty_mem[FlushAdr[1:0]];

    cache_flush_walker #(
        .NUMWAYS  (4),
        .NUMLINES (4),
        .SETLEN   (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .FlushCache   (FlushCache),
        .FlushStage   (FlushStage),
        .ValidWay     (ValidWay),
        .DirtyWay     (DirtyWay),
        .BusAck       (BusAck),
        .FlushAdr     (FlushAdr),
        .FlushWay     (FlushWay),
        .WriteBackReq (WriteBackReq),
        .ClearDirty   (ClearDirty),
        .FlushBusy    (FlushBusy),
        .FlushDone    (FlushDone)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input int set, input logic [3:0] v, input logic [3:0] d);
        for (int i = 0; i < 4; i++) begin
            valid_mem[i] = 4'b0;
            dirty_mem[i] = 4'b0;
        end
        if (set >= 0) begin
            valid_mem[set] = v;
            dirty_mem[set] = d;
        end
    endtask

    // Starts a walk at edge 0 and samples one cycle per loop pass. BusAck is
    // raised in the ack_delay-th WriteBackReq cycle; FlushStage / reset are
    // driven during the named cycle. Stops on the first idle cycle.
    task automatic run_walk(input int ack_delay, input int stage_cyc,
                            input int rst_cyc, input bit hold);
        int         wb_run  = 0;
        int         exp_idx = 0;
        bit         first   = 1'b1;
        logic [2:0] pa = '0;
        logic [3:0] pw = '0;
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; wb_cnt = 0; clr_cnt = 0;
        visits = 0; order_ok = 1'b1; finished = 1'b0;
        wb_adr = '0; wb_way = '0; clr_adr = '0; clr_way = '0;
        FlushCache = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (!hold) FlushCache = 1'b0;
            FlushStage = 1'b0;
            reset      = 1'b0;
            BusAck     = 1'b0;
            if (FlushBusy) begin
                busy_cnt++;
                if (first || FlushAdr != pa || FlushWay != pw) begin
                    if (FlushAdr != 3'(exp_idx / 4) || FlushWay != 4'(1 << (exp_idx % 4)))
                        order_ok = 1'b0;
                    exp_idx++;
                    visits++;
                    first = 1'b0;
                    pa = FlushAdr;
                    pw = FlushWay;
                end
            end
            if (FlushDone) begin
                done_cnt++;
                done_cyc = c;
            end
            if (WriteBackReq) begin
                wb_cnt++;
                wb_run++;
                wb_adr = FlushAdr;
                wb_way = FlushWay;
                BusAck = (wb_run >= ack_delay);
            end
            if (ClearDirty) begin
                clr_cnt++;
                clr_adr = FlushAdr;
                clr_way = FlushWay;
            end
            if (c > 1 && !FlushBusy) begin
                finished = 1'b1;
                break;
            end
            FlushStage = (c == stage_cyc);
            reset      = (c == rst_cyc);
        end
        chk("walk_terminated", 32'(finished), 32'd1);
    endtask

    initial begin
        reset = 1'b1; FlushCache = 1'b0; FlushStage = 1'b0; BusAck = 1'b0;
        set_mem(-1, 4'b0, 4'b0);
        step();
        step();
        chk("rst_adr",  32'(FlushAdr), 32'd0);
        chk("rst_way",  32'(FlushWay), 32'd1);
        chk("rst_busy", 32'(FlushBusy), 32'd0);
        chk("rst_done", 32'(FlushDone), 32'd0);
        chk("rst_wbr",  32'(WriteBackReq), 32'd0);
        chk("rst_clr",  32'(ClearDirty), 32'd0);
        reset = 1'b0;
        step();

        // Clean cache: 16 entries x 2 cycles, DONE in cycle 33.
        run_walk(1, 0, 0, 1'b0);
        $display("clean walk: done_cyc=%0d busy=%0d visits=%0d", done_cyc, busy_cnt, visits);
        chk("clean_done_cyc", 32'(done_cyc), 32'd33);
        chk("clean_done_cnt", 32'(done_cnt), 32'd1);
        chk("clean_busy",     32'(busy_cnt), 32'd33);
        chk("clean_wb",       32'(wb_cnt), 32'd0);
        chk("clean_visits",   32'(visits), 32'd16);
        chk("clean_order",    32'(order_ok), 32'd1);

        // One dirty line at set 2 way 1, acknowledged in the 3rd request cycle.
        set_mem(2, 4'b0010, 4'b0010);
        run_walk(3, 0, 0, 1'b0);
        $display("dirty walk: done_cyc=%0d wb=%0d clr=%0d", done_cyc, wb_cnt, clr_cnt);
        chk("dirty_wb_cnt",   32'(wb_cnt), 32'd3);
        chk("dirty_wb_adr",   32'(wb_adr), 32'd2);
        chk("dirty_wb_way",   32'(wb_way), 32'b0010);
        chk("dirty_clr_cnt",  32'(clr_cnt), 32'd1);
        chk("dirty_clr_adr",  32'(clr_adr), 32'd2);
        chk("dirty_clr_way",  32'(clr_way), 32'b0010);
        chk("dirty_done_cyc", 32'(done_cyc), 32'd37);
        chk("dirty_busy",     32'(busy_cnt), 32'd37);
        chk("dirty_order",    32'(order_ok), 32'd1);

        // Dirty but invalid: behaves exactly like a clean cache.
        set_mem(2, 4'b0000, 4'b0010);
        run_walk(1, 0, 0, 1'b0);
        $display("invalid-dirty walk: done_cyc=%0d wb=%0d", done_cyc, wb_cnt);
        chk("inv_wb",       32'(wb_cnt), 32'd0);
        chk("inv_done_cyc", 32'(done_cyc), 32'd33);
        chk("inv_clr",      32'(clr_cnt), 32'd0);

        // Abort during CHECK of entry (1,w2), which is cycle 14.
        set_mem(-1, 4'b0, 4'b0);
        run_walk(1, 14, 0, 1'b0);
        $display("abort in CHECK: busy=%0d visits=%0d done=%0d", busy_cnt, visits, done_cnt);
        chk("abchk_busy",   32'(busy_cnt), 32'd14);
        chk("abchk_visits", 32'(visits), 32'd7);
        chk("abchk_done",   32'(done_cnt), 32'd0);
        chk("abchk_adr",    32'(FlushAdr), 32'd0);
        chk("abchk_way",    32'(FlushWay), 32'b0001);

        // Abort in first WRITEBACK cycle (21); BusAck two cycles later.
        set_mem(2, 4'b0010, 4'b0010);
        run_walk(3, 21, 0, 1'b0);
        $display("abort in WRITEBACK: busy=%0d wb=%0d clr=%0d", busy_cnt, wb_cnt, clr_cnt);
        chk("abwb_wb",   32'(wb_cnt), 32'd3);
        chk("abwb_clr",  32'(clr_cnt), 32'd0);
        chk("abwb_done", 32'(done_cnt), 32'd0);
        chk("abwb_busy", 32'(busy_cnt), 32'd23);
        chk("abwb_adr",  32'(FlushAdr), 32'd0);

        // Reset during the second WRITEBACK cycle; a late BusAck is ignored.
        run_walk(10, 0, 22, 1'b0);
        $display("reset in WRITEBACK: busy=%0d wb=%0d", busy_cnt, wb_cnt);
        chk("rstwb_busy", 32'(busy_cnt), 32'd22);
        chk("rstwb_wb",   32'(wb_cnt), 32'd2);
        chk("rstwb_way",  32'(FlushWay), 32'd1);
        chk("rstwb_adr",  32'(FlushAdr), 32'd0);
        chk("rstwb_wbr",  32'(WriteBackReq), 32'd0);
        chk("rstwb_clr",  32'(ClearDirty), 32'd0);
        BusAck = 1'b1;
        step();
        BusAck = 1'b0;
        $display("late BusAck: busy=%0d wbr=%0d clr=%0d", FlushBusy, WriteBackReq, ClearDirty);
        chk("lateack_busy", 32'(FlushBusy), 32'd0);
        chk("lateack_wbr",  32'(WriteBackReq), 32'd0);
        chk("lateack_clr",  32'(ClearDirty), 32'd0);

        // FlushCache held: one idle cycle after DONE, then a fresh walk.
        set_mem(-1, 4'b0, 4'b0);
        run_walk(1, 0, 0, 1'b1);
        $display("held FlushCache: done_cyc=%0d", done_cyc);
        chk("hold_done_cyc", 32'(done_cyc), 32'd33);
        chk("hold_gap_busy", 32'(FlushBusy), 32'd0);
        step();
        chk("hold_restart_busy", 32'(FlushBusy), 32'd1);
        chk("hold_restart_adr",  32'(FlushAdr), 32'd0);
        chk("hold_restart_way",  32'(FlushWay), 32'b0001);
        FlushCache = 1'b0;
        FlushStage = 1'b1;
        step();
        FlushStage = 1'b0;
        chk("hold_abort_busy", 32'(FlushBusy), 32'd0);
        chk("hold_abort_done", 32'(FlushDone), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
